// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam bit IDLE_LEVEL_DEFAULT = 1'b0;

    // Bit-counter width for a frame of the given length (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        if (width <= 32'd2) begin
            return 32'd1;
        end
        return 32'($clog2(width));
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register; head_o is the next bit to leave in the chosen order.
module piso_shreg
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             shift_i,
    output logic             head_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else if (shift_i) begin
            // Vacated positions fill with zero so stale bits are never resent.
            q_d = MSB_FIRST ? {q_q[WIDTH-2:0], 1'b0} : {1'b0, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign head_o = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out transmitter with valid/ready load and frame strobes.
module piso_serial_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sout_q, sout_d;
    logic          sout_valid_q, sout_valid_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_end_q, frame_end_d;

    logic             handshake;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_head;
    logic             data_head;
    logic [WIDTH-1:0] data_rest;

    assign load_ready = ~rs & ((state_q == IDLE) | ((state_q == SHIFT) & (cnt_q == LAST)));
    assign handshake  = load_valid & load_ready;

    // The first bit goes straight to sout; the register keeps the remainder.
    assign data_head = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign data_rest = MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};

    piso_shreg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .rs     (rs),
        .load_i (sh_load),
        .d_i    (data_rest),
        .shift_i(sh_shift),
        .head_o (sh_head)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sout_d        = IDLE_LEVEL;
        sout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        sh_load       = 1'b0;
        sh_shift      = 1'b0;

        // A handshake only happens in IDLE or on the last bit, so it always opens a frame.
        if (handshake) begin
            state_d       = SHIFT;
            cnt_d         = '0;
            sh_load       = 1'b1;
            sout_d        = data_head;
            sout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d        = cnt_q + CW'(1);
                        sh_shift     = 1'b1;
                        sout_d       = sh_head;
                        sout_valid_d = 1'b1;
                        frame_end_d  = (cnt_q == PRE_LAST);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sout_q        <= IDLE_LEVEL;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = sout_valid_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: MSB-first vector table plus LSB-first sequences.
module tb_piso_serial_tx;

    logic       clk;
    logic       rs;
    logic       lv, lv2;
    logic [7:0] data, data2;

    logic rdy, sout, vld, fs, fe, bsy;
    logic rdy2, sout2, vld2, fs2, fe2, bsy2;

    int checks = 0;
    int errors = 0;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rs(rs), .load_valid(lv), .load_ready(rdy), .load_data(data),
        .sout(sout), .sout_valid(vld), .frame_start(fs), .frame_end(fe), .busy(bsy)
    );

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rs(rs), .load_valid(lv2), .load_ready(rdy2), .load_data(data2),
        .sout(sout2), .sout_valid(vld2), .frame_start(fs2), .frame_end(fe2), .busy(bsy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic       lv;
        logic [7:0] data;
        logic       rdy;
        logic       sout;
        logic       vld;
        logic       fs;
        logic       fe;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic l, input logic [7:0] d,
                                input logic erdy, input logic es, input logic ev,
                                input logic efs, input logic efe);
        vec_t v;
        v.rs = r; v.lv = l; v.data = d; v.rdy = erdy;
        v.sout = es; v.vld = ev; v.fs = efs; v.fe = efe;
        vecs.push_back(v);
    endfunction

    // Handshake row plus seven in-frame rows; expected bits come from the word, MSB first.
    function automatic void add_frame(input logic [7:0] word, input logic lv_after, input logic tog);
        add(1'b0, 1'b1, word, 1'b1, word[7], 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            add(1'b0, lv_after, tog ? (i[0] ? 8'hFF : 8'h00) : 8'h00,
                1'b0, word[7-i], 1'b1, 1'b0, i == 7);
        end
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_lsb(input logic [7:0] word, input logic [0:7] seq);
        @(negedge clk);
        lv2 = 1'b1; data2 = word;
        #1 chk("lsb_ready", rdy2, 1'b1);
        @(posedge clk); #1;
        chk("lsb_bit0", sout2, seq[0]);
        chk("lsb_start", fs2, 1'b1);
        chk("lsb_valid", vld2, 1'b1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            lv2 = 1'b0; data2 = ~data2;
            @(posedge clk); #1;
            chk($sformatf("lsb_bit%0d", i), sout2, seq[i]);
            chk($sformatf("lsb_end%0d", i), fe2, i == 7);
        end
        @(negedge clk);
        lv2 = 1'b0;
        @(posedge clk); #1;
        chk("lsb_idle_valid", vld2, 1'b0);
        chk("lsb_idle_sout", sout2, 1'b0);
    endtask

    initial begin
        rs = 1'b1; lv = 1'b0; lv2 = 1'b0; data = 8'h00; data2 = 8'h00;

        // Reset held three cycles with load_valid asserted.
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Single frame A5, then idle.
        add_frame(8'hA5, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Back-to-back FF then 00 with load_valid held high.
        add_frame(8'hFF, 1'b1, 1'b0);
        add_frame(8'h00, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset mid-frame, then a clean 81 frame.
        add(1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_frame(8'h81, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Data toggling while busy and not handshaken.
        add_frame(8'h3C, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rs = vecs[i].rs; lv = vecs[i].lv; data = vecs[i].data;
            #1 chk($sformatf("v%0d_ready", i), rdy, vecs[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("v%0d_sout", i), sout, vecs[i].sout);
            chk($sformatf("v%0d_valid", i), vld, vecs[i].vld);
            chk($sformatf("v%0d_start", i), fs, vecs[i].fs);
            chk($sformatf("v%0d_end", i), fe, vecs[i].fe);
            chk($sformatf("v%0d_busy", i), bsy, vecs[i].vld);
        end

        @(negedge clk);
        rs = 1'b0; lv = 1'b0;
        run_lsb(8'h01, 8'b1000_0000);
        run_lsb(8'hB4, 8'b0010_1101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
